// File: rtl/axi_line_fill_master.sv
// AXI4 read-only line-fill initiator: one critical-word-first WRAP burst per miss,
// early critical-word forward, full line reassembled in cache order.
module axi_line_fill_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             req_ready,
  output logic                             crit_valid,
  output logic [DATA_WIDTH-1:0]            crit_data,
  output logic                             line_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data,
  output logic                             line_err,
  output logic [3:0]                       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);
  localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_BITS  = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_req_ready;
  logic                  r_crit_valid;
  logic [DATA_WIDTH-1:0] r_crit_data;
  logic                  r_line_valid;
  logic                  r_line_err;
  logic                  r_err;
  logic [IDX_BITS-1:0]   r_w0;
  logic [IDX_BITS-1:0]   r_beat;
  logic [DATA_WIDTH-1:0] r_words [LINE_WORDS];

  logic [IDX_BITS-1:0]   w_idx;
  logic                  w_last_idx;
  logic                  w_beat_err;
  logic                  w_end;

  // Index arithmetic wraps naturally because LINE_WORDS is a power of two.
  assign w_idx      = r_w0 + r_beat;
  assign w_last_idx = (r_beat == IDX_BITS'(LINE_WORDS - 1));
  // RLAST must coincide exactly with the final beat; early or missing both flag an error.
  assign w_beat_err = r_err | (m_axi_rresp != 2'b00) | (m_axi_rlast != w_last_idx);
  assign w_end      = m_axi_rlast | w_last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_line_valid <= 1'b0;
      r_line_err   <= 1'b0;
      r_err        <= 1'b0;
      r_w0         <= '0;
      r_beat       <= '0;
      for (int unsigned k = 0; k < LINE_WORDS; k++) r_words[k] <= '0;
    end else begin
      r_crit_valid <= 1'b0;
      r_line_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_araddr    <= req_addr & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
            r_w0        <= req_addr[BYTE_BITS +: IDX_BITS];
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b1;
            r_state     <= S_AR;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            r_words[w_idx] <= m_axi_rdata;
            if (r_beat == '0) begin
              r_crit_data  <= m_axi_rdata;
              r_crit_valid <= 1'b1;
            end
            r_err  <= w_beat_err;
            r_beat <= r_beat + 1'b1;
            if (w_end) begin
              r_rready     <= 1'b0;
              r_line_valid <= 1'b1;
              r_line_err   <= w_beat_err;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_line_err  <= 1'b0;
          r_err       <= 1'b0;
          r_beat      <= '0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    line_data = '0;
    for (int unsigned k = 0; k < LINE_WORDS; k++) line_data[k*DATA_WIDTH +: DATA_WIDTH] = r_words[k];
  end

  assign req_ready     = r_req_ready;
  assign crit_valid    = r_crit_valid;
  assign crit_data     = r_crit_data;
  assign line_valid    = r_line_valid;
  assign line_err      = r_line_err;
  assign m_axi_arid    = 4'(AXI_ID);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'(BYTE_BITS);
  assign m_axi_arburst = 2'b10;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
endmodule

// File: tb/tb_axi_line_fill_master.sv
// Bench for axi_line_fill_master: behavioural AXI slave memory plus a line-level
// reference model; directed scenarios followed by randomized requests.
module tb_axi_line_fill_master;
  localparam int unsigned LW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          crit_valid;
  logic [DW-1:0] crit_data;
  logic          line_valid;
  logic [LW*DW-1:0] line_data;
  logic          line_err;
  logic [3:0]    m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  axi_line_fill_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LINE_WORDS(LW),
    .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .line_valid(line_valid), .line_data(line_data), .line_err(line_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave memory: word i holds i.
  logic [31:0] mem [1024];

  // Slave behaviour knobs for the next burst.
  int unsigned cfg_dly = 0;
  int          cfg_err_beat = -1;
  int          cfg_last_beat = LW - 1;

  // Behavioural AXI slave: one burst at a time, zero-wait data, configurable AR delay.
  int          s_phase;
  int unsigned s_cnt, s_beat, s_w0, s_base;
  bit          s_rst, s_ar_hs, s_r_hs;

  task automatic slave_drive_beat();
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = mem[s_base + (s_w0 + s_beat) % LW];
    m_axi_rresp  = (int'(s_beat) == cfg_err_beat) ? 2'b10 : 2'b00;
    m_axi_rlast  = (int'(s_beat) == cfg_last_beat);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    s_phase = 0; s_beat = 0; s_cnt = 0; s_w0 = 0; s_base = 0;
    forever begin
      @(negedge clk);
      s_rst   = rst;
      s_ar_hs = m_axi_arvalid && m_axi_arready;
      s_r_hs  = m_axi_rvalid && m_axi_rready;
      @(posedge clk); #1;
      if (s_rst) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        s_phase = 0;
      end else begin
        case (s_phase)
          0: if (m_axi_arvalid) begin
               s_w0   = (m_axi_araddr >> 2) % LW;
               s_base = (m_axi_araddr >> 2) & ~(LW - 1);
               s_cnt  = cfg_dly;
               if (s_cnt == 0) begin m_axi_arready = 1'b1; s_phase = 2; end
               else s_phase = 1;
             end
          1: begin
               s_cnt--;
               if (s_cnt == 0) begin m_axi_arready = 1'b1; s_phase = 2; end
             end
          2: if (s_ar_hs) begin
               m_axi_arready = 1'b0;
               s_beat = 0;
               slave_drive_beat();
               s_phase = 3;
             end
          3: if (s_r_hs) begin
               if (m_axi_rlast || s_beat == LW - 1) begin
                 m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                 s_phase = 0;
               end else begin
                 s_beat++;
                 slave_drive_beat();
               end
             end
          default: s_phase = 0;
        endcase
      end
    end
  end

  // Reference: line contents as the requester should see them.
  logic [31:0] model [LW];
  int unsigned last_line_cyc = 0;

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < LW; k++) v[k*32 +: 32] = model[k];
    return v;
  endfunction

  task automatic run_line(input logic [31:0] addr, input int unsigned dly, input int err_beat,
                          input int last_beat, input bit keep_valid, input bit b2b);
    logic [31:0] al;
    int unsigned w0, base, nb, acc, n_arv, n_crit;
    bit          eerr, accepted, got_line;
    al   = addr & ~32'h3;
    base = (al >> 2) & ~(LW - 1);
    w0   = (al >> 2) % LW;
    nb   = (last_beat >= 0 && last_beat < LW) ? last_beat + 1 : LW;
    eerr = (last_beat != LW - 1) || (err_beat >= 0 && err_beat < int'(nb));
    cfg_dly = dly; cfg_err_beat = err_beat; cfg_last_beat = last_beat;

    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    accepted = 0; acc = 0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (req_ready) begin accepted = 1; acc = cyc; end
    end
    if (!accepted) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", acc, last_line_cyc + 1);
    chk("line_held", line_data, model_vec());
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;

    for (int n = 0; n < int'(nb); n++) model[(w0 + n) % LW] = mem[base + (w0 + n) % LW];

    got_line = 0; n_arv = 0; n_crit = 0;
    for (int i = 0; i < 60 && !got_line; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) begin
        n_arv++;
        chk("araddr", m_axi_araddr, al);
        chk("rready_before_ar", m_axi_rready, 0);
        if (n_arv == 1) begin
          chk("arlen", m_axi_arlen, LW - 1);
          chk("arsize", m_axi_arsize, 2);
          chk("arburst", m_axi_arburst, 2'b10);
          chk("arid", m_axi_arid, 0);
        end
      end
      if (crit_valid) begin
        n_crit++;
        chk("crit_cycle", cyc, acc + 3 + dly);
        chk("crit_data", crit_data, mem[base + w0]);
      end
      if (line_valid) begin
        got_line = 1;
        last_line_cyc = cyc;
        chk("line_cycle", cyc, acc + 2 + dly + nb);
        chk("line_data", line_data, model_vec());
        chk("line_err", line_err, eerr);
      end
    end
    if (!got_line) chk("line_timeout", 0, 1);
    chk("arvalid_cycles", n_arv, dly + 1);
    chk("crit_pulses", n_crit, 1);
  endtask

  task automatic run_reset_mid(input logic [31:0] addr);
    bit accepted;
    int unsigned n_lv;
    cfg_dly = 0; cfg_err_beat = -1; cfg_last_beat = LW - 1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    accepted = 0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (req_ready) accepted = 1;
    end
    if (!accepted) chk("rst_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Accepted in cycle c; now in c+1. Beat 1 lands in c+3.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_line_data", line_data, 0);
    for (int k = 0; k < LW; k++) model[k] = '0;
    n_lv = 0;
    repeat (8) begin
      @(negedge clk);
      if (line_valid) n_lv++;
    end
    chk("rst_no_line_valid", n_lv, 0);
  endtask

  initial begin
    int r, eb, lb;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0;
    for (int k = 0; k < LW; k++) model[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_arvalid", m_axi_arvalid, 0);
    chk("reset_rready", m_axi_rready, 0);
    chk("reset_crit_valid", crit_valid, 0);
    chk("reset_line_valid", line_valid, 0);
    chk("reset_line_err", line_err, 0);
    chk("reset_araddr", m_axi_araddr, 0);
    chk("reset_line_data", line_data, 0);
    chk("reset_crit_data", crit_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_line(32'h108, 0, -1, LW - 1, 0, 0);
    run_line(32'h10F, 0, -1, LW - 1, 0, 0);
    run_line(32'h104, 5, -1, LW - 1, 0, 0);
    run_line(32'h120, 0, 2, LW - 1, 0, 0);
    run_line(32'h134, 0, -1, 1, 0, 0);
    run_line(32'h148, 1, -1, 99, 0, 0);
    run_reset_mid(32'h108);
    run_line(32'h200, 0, -1, LW - 1, 0, 0);
    run_line(32'h100, 0, -1, LW - 1, 1, 0);
    run_line(32'h110, 0, -1, LW - 1, 0, 1);

    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 9);
      lb = (r < 7) ? LW - 1 : (r < 9) ? $urandom_range(0, LW - 2) : 99;
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LW - 1) : -1;
      run_line($urandom_range(0, 4095), $urandom_range(0, 3), eb, lb, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
